// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scancode receive path.
package ps2_pkg;

    localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    // Bit positions of the prefix flags inside the 10-bit key event word.
    localparam int unsigned EVT_EXT_BIT = 9;
    localparam int unsigned EVT_BRK_BIT = 8;

    typedef enum logic [0:0] {
        StIdle,
        StRecv
    } frame_state_e;

    // Odd parity holds when data plus parity carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_input_conditioner.sv
// Synchronizes the raw PS/2 pins, glitch-filters the clock and flags its falling edges.
module ps2_input_conditioner #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall_evt,
    output logic data_s
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [CW-1:0]          filt_cnt_q, filt_cnt_d;
    logic                   filt_q, filt_d;
    logic                   filt_prev_q;
    logic                   clk_s;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Clock chain resets to the idle-high level so reset release cannot look like a fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '0;
            filt_cnt_q  <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            filt_cnt_q  <= filt_cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
        end
    end

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall_evt = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// Deframes PS/2 device-to-host frames and folds E0/F0 prefixes into 10-bit key events.
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] data_out,
    output logic       ready,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned     WD_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST      = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      BIT_CNT_LAST = 4'(PS2_FRAME_BITS - 1);

    logic fall_evt;
    logic data_s;

    ps2_input_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_cond (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall_evt (fall_evt),
        .data_s   (data_s)
    );

    frame_state_e    state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [8:0]      shift_q, shift_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            ext_q, ext_d;
    logic            brk_q, brk_d;
    logic [9:0]      data_q, data_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wd_q      <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wd_q      <= wd_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wd_d      = wd_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                wd_d = '0;
                // A start bit of 1 is line noise; drop it without flagging an error.
                if (fall_evt && !data_s) begin
                    state_d   = StRecv;
                    bit_cnt_d = 4'd1;
                end
            end
            StRecv: begin
                if (fall_evt) begin
                    wd_d = '0;
                    if (bit_cnt_q == BIT_CNT_LAST) begin
                        state_d   = StIdle;
                        bit_cnt_d = '0;
                        if (odd_parity_ok(shift_q) && data_s) begin
                            if (shift_q[7:0] == PS2_PREFIX_EXT) begin
                                ext_d = 1'b1;
                            end else if (shift_q[7:0] == PS2_PREFIX_BRK) begin
                                brk_d = 1'b1;
                            end else begin
                                data_d              = {2'b00, shift_q[7:0]};
                                data_d[EVT_EXT_BIT] = ext_q;
                                data_d[EVT_BRK_BIT] = brk_q;
                                ready_d             = 1'b1;
                                ext_d               = 1'b0;
                                brk_d               = 1'b0;
                            end
                        end else begin
                            err_d = 1'b1;
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end
                    end else begin
                        shift_d   = {data_s, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    wd_d      = '0;
                    err_d     = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_out  = data_q;
    assign ready     = ready_q;
    assign frame_err = err_q;
    assign busy      = (bit_cnt_q != 4'd0);

endmodule
